// File: rtl/seg_msg_writer_if.sv
// seg_msg_writer_if: keypad/status inputs and per-digit write bus of the display writer
interface seg_msg_writer_if #(
    parameter int SEGMENT_NUM = 6,
    parameter int W_DATA      = 5
);
    logic [3:0]                    key_num;
    logic                          key_vld;
    logic                          key_clr;
    logic [1:0]                    status;
    logic                          status_vld;
    logic [SEGMENT_NUM*W_DATA-1:0] din;
    logic [SEGMENT_NUM-1:0]        din_vld;
    logic                          busy;
    modport master (
        output key_num, key_vld, key_clr, status, status_vld,
        input  din, din_vld, busy
    );
    modport slave (
        input  key_num, key_vld, key_clr, status, status_vld,
        output din, din_vld, busy
    );
endinterface

// File: rtl/seg_msg_writer.sv
// seg_msg_writer: writes keypad entry or status message images one digit slot at a time
module seg_msg_writer #(
    parameter int SEGMENT_NUM = 6,
    parameter int W_DATA      = 5,
    parameter int WR_HOLD     = 8,
    parameter int HOLD_CYC    = 50_000_000
) (
    input logic             clk,
    input logic             rst,
    seg_msg_writer_if.slave bus
);
    localparam int KW = $clog2(SEGMENT_NUM + 1);
    localparam int WW = $clog2(WR_HOLD + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [KW-1:0] K_LAST = KW'(SEGMENT_NUM - 1);
    localparam logic [WW-1:0] W_LAST = WW'(WR_HOLD - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYC - 1);
    localparam logic [W_DATA-1:0] BLANK = W_DATA'(5'h1F);
    localparam logic [5:0][4:0] OPEN_IMG  = {5'h1F, 5'h1F, 5'h10, 5'h11, 5'h12, 5'h13};
    localparam logic [5:0][4:0] LOCK_IMG  = {5'h1F, 5'h1F, 5'h14, 5'h10, 5'h15, 5'h16};
    localparam logic [5:0][4:0] ERROR_IMG = {5'h1F, 5'h1F, 5'h1F, 5'h12, 5'h18, 5'h18};
    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;
    state_t                               state_q;
    logic [SEGMENT_NUM-1:0][W_DATA-1:0]   din_q;
    logic [SEGMENT_NUM-1:0]               din_vld_q;
    logic                                 busy_q;
    logic [5:0][3:0]                      buf_q;
    logic [2:0]                           n_q;
    logic                                 msg_q;
    logic [1:0]                           sel_q;
    logic                                 pend_q;
    logic [KW-1:0]                        k_q;
    logic [WW-1:0]                        wcnt_q;
    logic [HW-1:0]                        hcnt_q;
    logic [KW-1:0]                        ld_k;
    logic [5:0][4:0]                      msg_img;
    logic [W_DATA-1:0]                    code_d;
    logic [SEGMENT_NUM-1:0]               vld_d;
    logic                                 key_ok;
    // ld_k is the slot that would be loaded on this edge: 0 when starting, k+1 when advancing
    assign ld_k    = (state_q == WRITE) ? k_q + 1'b1 : '0;
    assign msg_img = (sel_q == 2'b01) ? OPEN_IMG : (sel_q == 2'b10) ? LOCK_IMG : ERROR_IMG;
    assign code_d  = (int'(ld_k) > 5) ? BLANK :
                     msg_q ? W_DATA'(msg_img[ld_k]) :
                     (ld_k < n_q) ? W_DATA'({1'b0, buf_q[ld_k]}) : BLANK;
    assign vld_d   = SEGMENT_NUM'(1) << ld_k;
    assign key_ok  = bus.key_vld && bus.key_num <= 4'd9 && n_q != 3'd6;
    assign bus.din     = din_q;
    assign bus.din_vld = din_vld_q;
    assign bus.busy    = busy_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            din_q     <= {SEGMENT_NUM{BLANK}};
            din_vld_q <= '0;
            busy_q    <= 1'b0;
            buf_q     <= '0;
            n_q       <= '0;
            msg_q     <= 1'b0;
            sel_q     <= '0;
            pend_q    <= 1'b1;
            k_q       <= '0;
            wcnt_q    <= '0;
            hcnt_q    <= '0;
        end else if (bus.status_vld) begin
            // status aborts whatever is running; the restart goes through IDLE so din_vld drops for a cycle
            msg_q     <= bus.status != 2'b00;
            sel_q     <= bus.status;
            n_q       <= (bus.status == 2'b00) ? 3'd0 : n_q;
            state_q   <= IDLE;
            din_vld_q <= '0;
            busy_q    <= 1'b0;
            pend_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (pend_q) begin
                    state_q       <= WRITE;
                    pend_q        <= 1'b0;
                    busy_q        <= 1'b1;
                    k_q           <= ld_k;
                    wcnt_q        <= '0;
                    din_q[ld_k]   <= code_d;
                    din_vld_q     <= vld_d;
                end
                WRITE: if (wcnt_q != W_LAST) begin
                    wcnt_q <= wcnt_q + 1'b1;
                end else if (k_q != K_LAST) begin
                    k_q         <= ld_k;
                    wcnt_q      <= '0;
                    din_q[ld_k] <= code_d;
                    din_vld_q   <= vld_d;
                end else begin
                    din_vld_q <= '0;
                    state_q   <= msg_q ? HOLD : IDLE;
                    busy_q    <= msg_q;
                    hcnt_q    <= '0;
                end
                default: if (hcnt_q != H_LAST) begin
                    hcnt_q <= hcnt_q + 1'b1;
                end else begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    msg_q   <= 1'b0;
                    n_q     <= '0;
                    pend_q  <= 1'b1;
                end
            endcase
            if (!msg_q && (bus.key_clr || key_ok)) begin
                pend_q <= 1'b1;
                n_q    <= bus.key_clr ? 3'd0 : n_q + 1'b1;
                buf_q  <= bus.key_clr ? buf_q : {buf_q[4:0], bus.key_num};
            end
        end
    end
endmodule

// File: tb/tb_seg_msg_writer.sv
// tb_seg_msg_writer: directed scenarios for the entry/message display writer
module tb_seg_msg_writer;
    localparam logic [29:0] BLANK_IMG = {6{5'h1F}};
    localparam logic [29:0] OPEN_IMG  = {5'h1F, 5'h1F, 5'h10, 5'h11, 5'h12, 5'h13};
    localparam logic [29:0] LOCK_IMG  = {5'h1F, 5'h1F, 5'h14, 5'h10, 5'h15, 5'h16};
    localparam logic [29:0] ERROR_IMG = {5'h1F, 5'h1F, 5'h1F, 5'h12, 5'h18, 5'h18};
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seg_msg_writer_if #(.SEGMENT_NUM(6), .W_DATA(5)) bus();
    seg_msg_writer #(.SEGMENT_NUM(6), .W_DATA(5), .WR_HOLD(8), .HOLD_CYC(20)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic kv, input logic [3:0] kn, input logic kc,
                          input logic sv, input logic [1:0] st);
        bus.key_vld = kv; bus.key_num = kn; bus.key_clr = kc;
        bus.status_vld = sv; bus.status = st;
        tick(1);
        bus.key_vld = 1'b0; bus.key_clr = 1'b0; bus.status_vld = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        strobe(1'b1, k, 1'b0, 1'b0, 2'b00);
    endtask

    // cycles until busy has been low on two consecutive samples; -1 if the budget runs out
    task automatic wait_quiet(output int cyc);
        int q = 0;
        cyc = 0;
        while (q < 2 && cyc < 400) begin
            tick(1);
            cyc++;
            q = bus.busy ? 0 : q + 1;
        end
        if (q < 2) cyc = -1;
    endtask

    task automatic test_reset;
        bus.key_num = 4'd0; bus.key_vld = 1'b0; bus.key_clr = 1'b0;
        bus.status = 2'b00; bus.status_vld = 1'b0;
        rst = 1'b1;
        tick(3);
        checks++;
        if ({bus.busy, bus.din_vld, bus.din} !== {1'b0, 6'b0, BLANK_IMG}) begin
            errors++;
            $display("FAIL reset_state got busy=%b vld=%b din=%h exp busy=0 vld=0 din=%h", bus.busy, bus.din_vld, bus.din, BLANK_IMG);
        end
        rst = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        checks++;
        if ({bus.busy, bus.din_vld} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_write got busy=%b vld=%b exp 0/000000", bus.busy, bus.din_vld);
        end
        rst = 1'b0;
        for (int i = 0; i < 48; i++) begin
            logic [5:0] ev;
            tick(1);
            ev = 6'(1 << (i / 8));
            checks++;
            if ({bus.busy, bus.din_vld, bus.din} !== {1'b1, ev, BLANK_IMG}) begin
                errors++;
                $display("FAIL reset_refresh cyc=%0d got busy=%b vld=%b din=%h exp busy=1 vld=%b din=%h", i, bus.busy, bus.din_vld, bus.din, ev, BLANK_IMG);
            end
        end
        tick(1);
        checks++;
        if ({bus.busy, bus.din_vld} !== 7'b0) begin
            errors++;
            $display("FAIL reset_refresh_end got busy=%b vld=%b exp 0/000000", bus.busy, bus.din_vld);
        end
    endtask

    task automatic test_keys;
        int cyc;
        press(4'd1); press(4'd2); press(4'd3);
        wait_quiet(cyc);
        checks++;
        if (cyc != 97) begin
            errors++;
            $display("FAIL keys_duration got %0d exp 97", cyc);
        end
        checks++;
        if (bus.din !== {5'h1F, 5'h1F, 5'h1F, 5'h01, 5'h02, 5'h03}) begin
            errors++;
            $display("FAIL keys_image got %h exp 1F,1F,1F,01,02,03", bus.din);
        end
    endtask

    task automatic test_overflow;
        int cyc;
        logic [29:0] full = {5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06};
        press(4'd4); press(4'd5); press(4'd6);
        wait_quiet(cyc);
        checks++;
        if (bus.din !== full) begin
            errors++;
            $display("FAIL six_keys_image got %h exp %h", bus.din, full);
        end
        press(4'd7);
        tick(2);
        checks++;
        if ({bus.busy, bus.din} !== {1'b0, full}) begin
            errors++;
            $display("FAIL seventh_key_ignored got busy=%b din=%h exp busy=0 din=%h", bus.busy, bus.din, full);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        strobe(1'b0, 4'd0, 1'b1, 1'b0, 2'b00);
        tick(5);
        press(4'd9);
        tick(43);
        checks++;
        if ({bus.busy, bus.din_vld} !== 7'b0) begin
            errors++;
            $display("FAIL b2b_gap got busy=%b vld=%b exp 0/000000", bus.busy, bus.din_vld);
        end
        tick(1);
        checks++;
        if ({bus.busy, bus.din_vld} !== {1'b1, 6'b000001}) begin
            errors++;
            $display("FAIL b2b_restart got busy=%b vld=%b exp 1/000001", bus.busy, bus.din_vld);
        end
        wait_quiet(cyc);
        checks++;
        if (cyc != 49) begin
            errors++;
            $display("FAIL b2b_duration got %0d exp 49", cyc);
        end
        checks++;
        if (bus.din !== {{5{5'h1F}}, 5'h09}) begin
            errors++;
            $display("FAIL b2b_image got %h exp 1F,1F,1F,1F,1F,09", bus.din);
        end
        press(4'd12);
        tick(2);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL nondigit_ignored got busy=%b exp 0", bus.busy);
        end
    endtask

    task automatic test_clr_wins;
        int cyc;
        strobe(1'b1, 4'd7, 1'b1, 1'b0, 2'b00);
        wait_quiet(cyc);
        checks++;
        if (cyc != 50) begin
            errors++;
            $display("FAIL clr_wins_duration got %0d exp 50", cyc);
        end
        checks++;
        if (bus.din !== BLANK_IMG) begin
            errors++;
            $display("FAIL clr_wins_image got %h exp %h", bus.din, BLANK_IMG);
        end
    endtask

    task automatic test_open;
        int cyc;
        press(4'd4);
        tick(10);
        strobe(1'b0, 4'd0, 1'b0, 1'b1, 2'b01);
        checks++;
        if ({bus.busy, bus.din_vld} !== 7'b0) begin
            errors++;
            $display("FAIL open_abort got busy=%b vld=%b exp 0/000000", bus.busy, bus.din_vld);
        end
        tick(1);
        checks++;
        if ({bus.din_vld, bus.din[4:0]} !== {6'b000001, 5'h13}) begin
            errors++;
            $display("FAIL open_first_slot got vld=%b d0=%h exp 000001/13", bus.din_vld, bus.din[4:0]);
        end
        tick(48);
        checks++;
        if ({bus.busy, bus.din_vld, bus.din} !== {1'b1, 6'b0, OPEN_IMG}) begin
            errors++;
            $display("FAIL open_hold got busy=%b vld=%b din=%h exp 1/000000/%h", bus.busy, bus.din_vld, bus.din, OPEN_IMG);
        end
        press(4'd5);
        tick(18);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL open_hold_len got busy=%b exp 1", bus.busy);
        end
        tick(1);
        checks++;
        if ({bus.busy, bus.din} !== {1'b0, OPEN_IMG}) begin
            errors++;
            $display("FAIL open_hold_end got busy=%b din=%h exp 0/%h", bus.busy, bus.din, OPEN_IMG);
        end
        wait_quiet(cyc);
        checks++;
        if (cyc != 50 || bus.din !== BLANK_IMG) begin
            errors++;
            $display("FAIL open_blank_refresh got cyc=%0d din=%h exp 50/%h", cyc, bus.din, BLANK_IMG);
        end
    endtask

    task automatic test_lock_cancel;
        int cyc;
        press(4'd7);
        wait_quiet(cyc);
        checks++;
        if (bus.din[4:0] !== 5'h07) begin
            errors++;
            $display("FAIL entry_seven got %h exp 07", bus.din[4:0]);
        end
        strobe(1'b0, 4'd0, 1'b0, 1'b1, 2'b10);
        tick(49);
        checks++;
        if ({bus.busy, bus.din} !== {1'b1, LOCK_IMG}) begin
            errors++;
            $display("FAIL lock_image got busy=%b din=%h exp 1/%h", bus.busy, bus.din, LOCK_IMG);
        end
        strobe(1'b0, 4'd0, 1'b0, 1'b1, 2'b00);
        checks++;
        if ({bus.busy, bus.din_vld} !== 7'b0) begin
            errors++;
            $display("FAIL cancel_abort got busy=%b vld=%b exp 0/000000", bus.busy, bus.din_vld);
        end
        wait_quiet(cyc);
        checks++;
        if (cyc != 50 || bus.din !== BLANK_IMG) begin
            errors++;
            $display("FAIL cancel_blank got cyc=%0d din=%h exp 50/%h", cyc, bus.din, BLANK_IMG);
        end
    endtask

    task automatic test_error_key;
        int cyc;
        strobe(1'b1, 4'd8, 1'b0, 1'b1, 2'b11);
        tick(49);
        checks++;
        if ({bus.busy, bus.din_vld, bus.din} !== {1'b1, 6'b0, ERROR_IMG}) begin
            errors++;
            $display("FAIL error_image got busy=%b vld=%b din=%h exp 1/000000/%h", bus.busy, bus.din_vld, bus.din, ERROR_IMG);
        end
        wait_quiet(cyc);
        checks++;
        if (cyc != 70 || bus.din !== BLANK_IMG) begin
            errors++;
            $display("FAIL error_key_absent got cyc=%0d din=%h exp 70/%h", cyc, bus.din, BLANK_IMG);
        end
    endtask

    initial begin
        test_reset;
        test_keys;
        test_overflow;
        test_back_to_back;
        test_clr_wins;
        test_open;
        test_lock_cancel;
        test_error_key;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
